// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle for pipe_stage_reg: upstream valid/ready/data/ctrl/bubble,
// downstream valid/ready/data/ctrl and the flush strobe.
interface pipe_stage_reg_if #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              in_bubble;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;

  modport slave (
    input  in_valid, in_data, in_ctrl, in_bubble, flush, out_ready,
    output in_ready, out_valid, out_data, out_ctrl
  );

  modport master (
    output in_valid, in_data, in_ctrl, in_bubble, flush, out_ready,
    input  in_ready, out_valid, out_data, out_ctrl
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline stage register with a 2-entry skid buffer, bubble and flush.
// Optional perf counters are built only when PIPE_STAGE_PERF_EN is defined.
//
// state | meaning
// EMPTY | main invalid, skid invalid
// ONE   | main valid, skid invalid
// FULL  | main and skid valid, in_ready low
module pipe_stage_reg #(
  parameter int                DATA_W   = 32,
  parameter int                CTRL_W   = 16,
  parameter logic [CTRL_W-1:0] CTRL_NOP = {CTRL_W{1'b0}}
) (
  input  logic                clk,
  input  logic                rst,
  pipe_stage_reg_if.slave     bus,
  input  logic                perf_clr,
  output logic [31:0]         perf_stall_cnt,
  output logic [31:0]         perf_bubble_cnt
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t            state_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] main_data_q;
  logic [CTRL_W-1:0] main_ctrl_q;
  logic [DATA_W-1:0] skid_data_q;
  logic [CTRL_W-1:0] skid_ctrl_q;

  logic              accept;
  logic              emit;
  logic [CTRL_W-1:0] beat_ctrl;

  assign accept    = bus.in_valid & in_ready_q;
  assign emit      = out_valid_q & bus.out_ready;
  assign beat_ctrl = bus.in_bubble ? CTRL_NOP : bus.in_ctrl;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      main_data_q <= '0;
      main_ctrl_q <= CTRL_NOP;
      skid_data_q <= '0;
      skid_ctrl_q <= CTRL_NOP;
    end else if (bus.flush) begin
      // Data registers keep their contents; only control is neutralised.
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      main_ctrl_q <= CTRL_NOP;
      skid_ctrl_q <= CTRL_NOP;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            main_data_q <= bus.in_data;
            main_ctrl_q <= beat_ctrl;
            out_valid_q <= 1'b1;
            state_q     <= ONE;
          end
        end
        ONE: begin
          if (accept && emit) begin
            main_data_q <= bus.in_data;
            main_ctrl_q <= beat_ctrl;
          end else if (accept) begin
            skid_data_q <= bus.in_data;
            skid_ctrl_q <= beat_ctrl;
            in_ready_q  <= 1'b0;
            state_q     <= FULL;
          end else if (emit) begin
            main_ctrl_q <= CTRL_NOP;
            out_valid_q <= 1'b0;
            state_q     <= EMPTY;
          end
        end
        FULL: begin
          if (emit) begin
            main_data_q <= skid_data_q;
            main_ctrl_q <= skid_ctrl_q;
            skid_ctrl_q <= CTRL_NOP;
            in_ready_q  <= 1'b1;
            state_q     <= ONE;
          end
        end
        default: begin
          state_q     <= EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          main_ctrl_q <= CTRL_NOP;
          skid_ctrl_q <= CTRL_NOP;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = main_data_q;
  assign bus.out_ctrl  = main_ctrl_q;

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  // Clear beats increment; both counters stick at all-ones.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (perf_clr) begin
      stall_cnt_d  = '0;
      bubble_cnt_d = '0;
    end else begin
      if (bus.in_valid && !in_ready_q && (stall_cnt_q != 32'hFFFF_FFFF))
        stall_cnt_d = stall_cnt_q + 32'd1;
      if (accept && bus.in_bubble && (bubble_cnt_q != 32'hFFFF_FFFF))
        bubble_cnt_d = bubble_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign perf_stall_cnt  = stall_cnt_q;
  assign perf_bubble_cnt = bubble_cnt_q;
`else
  logic unused_perf_clr;
  assign unused_perf_clr = perf_clr;
  assign perf_stall_cnt  = 32'h0;
  assign perf_bubble_cnt = 32'h0;
`endif

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised, handshaked pipeline stage register; next generation of the fixed-field ID/EX latch.
- Carries an opaque data payload and a control field between any two CPU stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Provides valid/ready flow control, a 2-entry skid buffer for a fully registered in_ready, per-beat bubble insertion (control zeroed, data kept) and a synchronous flush.

Parameters:
- DATA_W, 32, payload width; never cleared by bubble or flush.
- CTRL_W, 16, control-field width; forced to CTRL_NOP on bubble, flush and reset.
- CTRL_NOP, {CTRL_W{1'b0}}, control value that denotes a no-op.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream beat present.
- in_ready  out  1  stage can accept a beat; registered.
- in_data  in  DATA_W  upstream payload.
- in_ctrl  in  CTRL_W  upstream control field.
- in_bubble  in  1  beat is accepted but its control is replaced by CTRL_NOP.
- flush  in  1  synchronous kill of all held beats.
- out_valid  out  1  downstream beat present; registered.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  held payload.
- out_ctrl  out  CTRL_W  held control; equals CTRL_NOP whenever out_valid=0.
- perf_clr  in  1  synchronous clear of the perf counters.
- perf_stall_cnt  out  32  cycles with in_valid=1 and in_ready=0.
- perf_bubble_cnt  out  32  accepted beats with in_bubble=1.

Behaviour:
- Handshakes: accept = in_valid & in_ready; emit = out_valid & out_ready.
- Storage: main entry (drives the outputs) plus skid entry, each holding data, ctrl and valid.
- State EMPTY (main invalid):
  - accept -> ONE, main <= beat.
- State ONE (main valid, skid invalid):
  - accept & emit -> ONE, main <= beat.
  - accept & !emit -> FULL, skid <= beat.
  - !accept & emit -> EMPTY.
  - otherwise hold.
- State FULL (both valid), in_ready=0:
  - emit -> ONE, main <= skid.
  - otherwise hold.
- Encodings: in_ready = (state != FULL); out_valid = (state != EMPTY). Both come straight from flops, with no combinational path from out_ready or in_valid.
- Latency: 1 cycle from accept to out_valid when EMPTY, or when ONE with simultaneous emit. Throughput is 1 beat/cycle with out_ready held high.
- Ordering: strictly FIFO; a beat is never dropped or duplicated, except on flush.
- Bubble: the captured ctrl is CTRL_NOP and the data is captured unchanged. The beat still counts as a valid beat (out_valid=1).
- Flush (priority over all except rst):
  - Next state EMPTY; both ctrl fields <= CTRL_NOP; data registers hold.
  - A beat accepted in the flush cycle is discarded.
  - The emit in the flush cycle still completes downstream.
  - in_ready=1 and out_valid=0 from the next cycle.
- Reset (asynchronous, any time including mid-transfer):
  - State EMPTY, in_ready=1, out_valid=0.
  - out_data=0, out_ctrl=CTRL_NOP, skid cleared.
  - Perf counters=0.
- Simultaneous events:
  - flush & accept: flush wins.
  - perf_clr and an increment in the same cycle: clear wins.
- Widths: no arithmetic on the payload. Perf counters saturate at 32'hFFFF_FFFF with no wrap.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- Defined: perf_stall_cnt and perf_bubble_cnt are live saturating counters as above; perf_clr is honoured.
- Undefined: no counter flops are built; both outputs are tied to 32'h0 and perf_clr is ignored. The port list is identical in both builds.

Test Plan:
- Reset: assert rst asynchronously mid-cycle while FULL -> immediately out_valid=0, in_ready=1, out_ctrl=16'h0000, out_data=0; counters=0.
- Streaming: out_ready=1; beats data=32'h1000_0000+i, ctrl=16'h00A0+i for i=0..7 on consecutive cycles -> identical sequence on the output 1 cycle later, in_ready constantly 1.
- Backpressure/skid: out_ready=0; send data=32'hDEAD_0001 then 32'hDEAD_0002.
  - Expect in_ready=0 after the 2nd accept.
  - Hold 3 cycles with in_valid=1 -> perf_stall_cnt=3 (PERF_EN).
  - Raise out_ready -> outputs 32'hDEAD_0001 then 32'hDEAD_0002 in order.
- Bubble: accept data=32'h0040_0010, ctrl=16'h1F3C, in_bubble=1 -> out_valid=1, out_data=32'h0040_0010, out_ctrl=16'h0000; perf_bubble_cnt increments by 1.
- Flush: state FULL plus a new in_valid beat; assert flush for 1 cycle -> next cycle out_valid=0, in_ready=1, out_ctrl=16'h0000; the three beats never appear at the output.
- Saturation: force perf_stall_cnt to 32'hFFFF_FFFE and stall 4 cycles -> reads 32'hFFFF_FFFF; perf_clr -> 0. With the macro undefined, both counters read 0 throughout.
